// File: rtl/ahb_lite_sdram_fifo_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_lite_sdram_fifo_pipe
//  Brief    : Pipelined AHB-Lite slave front end feeding command, write-data
//             and read-data FIFOs of an SDRAM engine. Posted writes, zero-wait
//             bursts when FIFOs have room, optional read timeout with ERROR
//             response and discard of late read data.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_lite_sdram_fifo_pipe #(
    parameter  int ADDR_WIDTH    = 32,
    parameter  int DATA_WIDTH    = 32,
    parameter  int RD_TIMEOUT    = 0,
    parameter  int TIMEOUT_WIDTH = 16,
    parameter  int DROP_WIDTH    = 3,
    localparam int CMD_WIDTH     = ADDR_WIDTH + 4
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [2:0]            HBURST,
    input  logic                  HSEL,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic                  CFIFO_WEN,
    output logic [CMD_WIDTH-1:0]  CFIFO_WDATA,
    input  logic                  CFIFO_WFULL,
    output logic                  WFIFO_WEN,
    output logic [DATA_WIDTH-1:0] WFIFO_WDATA,
    input  logic                  WFIFO_WFULL,
    output logic                  RFIFO_REN,
    input  logic [DATA_WIDTH-1:0] RFIFO_RDATA,
    input  logic                  RFIFO_REMPTY
);

    localparam logic [TIMEOUT_WIDTH-1:0] C_TIMEOUT  = TIMEOUT_WIDTH'(RD_TIMEOUT);
    localparam logic [TIMEOUT_WIDTH-1:0] C_WAIT_ONE = TIMEOUT_WIDTH'(1);
    localparam logic [DROP_WIDTH-1:0]    C_DROP_ONE = DROP_WIDTH'(1);
    localparam logic [DROP_WIDTH-1:0]    C_DROP_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t                  state_q,    state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
    logic [2:0]              size_q,     size_d;
    logic                    write_q,    write_d;
    logic                    cmd_sent_q, cmd_sent_d;
    logic [TIMEOUT_WIDTH-1:0] wait_q,    wait_d;
    logic [DROP_WIDTH-1:0]   drop_q,     drop_d;

    logic w_discard;
    logic w_data_ok;
    logic w_timeout;
    logic w_can_accept;
    logic w_accept;
    logic w_rd_ret;
    logic w_drop_inc;

    // HBURST and the SEQ/NONSEQ distinction carry no information for this slave.
    logic w_unused_ok;
    assign w_unused_ok = ^{HBURST, HTRANS[0]};

    assign HRDATA      = RFIFO_RDATA;
    assign WFIFO_WDATA = HWDATA;
    assign CFIFO_WDATA = {write_q, size_q, addr_q};

    // Stale words left by timed-out reads are popped before any live read data.
    assign w_discard = (drop_q != '0) && !RFIFO_REMPTY;
    assign w_data_ok = cmd_sent_q && (drop_q == '0) && !RFIFO_REMPTY;
    // Timeout is held off while the discard counter cannot record another stale word.
    assign w_timeout = (C_TIMEOUT != '0) && (wait_q == C_TIMEOUT) && (drop_q != C_DROP_MAX);

    // State register and transfer context, cleared asynchronously.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            cmd_sent_q <= 1'b0;
            wait_q     <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            write_q    <= write_d;
            cmd_sent_q <= cmd_sent_d;
            wait_q     <= wait_d;
            drop_q     <= drop_d;
        end
    end

    // Next-state, bus response and FIFO strobes for the current data phase.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        write_d      = write_q;
        cmd_sent_d   = cmd_sent_q;
        wait_d       = wait_q;
        HREADYOUT    = 1'b1;
        HRESP        = 1'b0;
        CFIFO_WEN    = 1'b0;
        WFIFO_WEN    = 1'b0;
        w_rd_ret     = 1'b0;
        w_drop_inc   = 1'b0;
        w_can_accept = 1'b0;

        case (state_q)
            S_IDLE: begin
                w_can_accept = 1'b1;
            end
            S_WRITE: begin
                // Command and data go out together or not at all.
                if (!CFIFO_WFULL && !WFIFO_WFULL) begin
                    CFIFO_WEN    = 1'b1;
                    WFIFO_WEN    = 1'b1;
                    state_d      = S_IDLE;
                    w_can_accept = 1'b1;
                end else begin
                    HREADYOUT = 1'b0;
                end
            end
            S_READ: begin
                HREADYOUT = 1'b0;
                if (w_data_ok) begin
                    // Data beats a timeout that would fire in the same cycle.
                    HREADYOUT    = 1'b1;
                    w_rd_ret     = 1'b1;
                    cmd_sent_d   = 1'b0;
                    state_d      = S_IDLE;
                    w_can_accept = 1'b1;
                end else if (w_timeout) begin
                    HRESP      = 1'b1;
                    state_d    = S_ERR;
                    cmd_sent_d = 1'b0;
                    w_drop_inc = cmd_sent_q;
                end else begin
                    if (!cmd_sent_q && !CFIFO_WFULL) begin
                        CFIFO_WEN  = 1'b1;
                        cmd_sent_d = 1'b1;
                    end
                    // Saturating at the limit lets a suppressed timeout fire
                    // as soon as the discard counter has room again.
                    if (wait_q != C_TIMEOUT) begin
                        wait_d = wait_q + C_WAIT_ONE;
                    end
                end
            end
            default: begin
                // Second ERROR cycle; the failed transfer's successor is not taken.
                HRESP   = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        w_accept = w_can_accept & HSEL & HREADY & HTRANS[1];
        if (w_accept) begin
            addr_d     = HADDR;
            size_d     = HSIZE;
            write_d    = HWRITE;
            cmd_sent_d = 1'b0;
            wait_d     = '0;
            state_d    = HWRITE ? S_WRITE : S_READ;
        end
    end

    // Read-FIFO pop for either a live response or a discarded stale word.
    always_comb begin
        RFIFO_REN = w_discard | w_rd_ret;
        drop_d    = drop_q;
        if (w_drop_inc && !w_discard) begin
            drop_d = drop_q + C_DROP_ONE;
        end else if (w_discard && !w_drop_inc) begin
            drop_d = drop_q - C_DROP_ONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_sdram_fifo_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_lite_sdram_fifo_pipe
//  Brief    : Scoreboard bench for ahb_lite_sdram_fifo_pipe with a read-FIFO
//             model; directed AHB transfers, monitor compares FIFO traffic
//             and bus responses against queued expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_sdram_fifo_pipe;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = AW + 4;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic [AW-1:0] HADDR = '0;
    logic [2:0]    HBURST = '0;
    logic          HSEL = 1'b0;
    logic [2:0]    HSIZE = '0;
    logic [1:0]    HTRANS = '0;
    logic [DW-1:0] HWDATA = '0;
    logic          HWRITE = 1'b0;
    logic          HREADY;
    logic [DW-1:0] HRDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic          CFIFO_WEN;
    logic [CW-1:0] CFIFO_WDATA;
    logic          CFIFO_WFULL = 1'b0;
    logic          WFIFO_WEN;
    logic [DW-1:0] WFIFO_WDATA;
    logic          WFIFO_WFULL = 1'b0;
    logic          RFIFO_REN;
    logic [DW-1:0] RFIFO_RDATA;
    logic          RFIFO_REMPTY;

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    ahb_lite_sdram_fifo_pipe #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(8),
        .TIMEOUT_WIDTH(16), .DROP_WIDTH(3)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HBURST(HBURST),
        .HSEL(HSEL), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HREADY(HREADY), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .CFIFO_WEN(CFIFO_WEN),
        .CFIFO_WDATA(CFIFO_WDATA), .CFIFO_WFULL(CFIFO_WFULL),
        .WFIFO_WEN(WFIFO_WEN), .WFIFO_WDATA(WFIFO_WDATA),
        .WFIFO_WFULL(WFIFO_WFULL), .RFIFO_REN(RFIFO_REN),
        .RFIFO_RDATA(RFIFO_RDATA), .RFIFO_REMPTY(RFIFO_REMPTY)
    );

    // Show-ahead read FIFO model
    logic [DW-1:0] rmem [16];
    logic [3:0]    wr_ptr = '0;
    logic [3:0]    rd_ptr = '0;
    assign RFIFO_REMPTY = (rd_ptr == wr_ptr);
    assign RFIFO_RDATA  = rmem[rd_ptr];
    always @(posedge HCLK) if (RFIFO_REN && !RFIFO_REMPTY) rd_ptr <= rd_ptr + 4'd1;

    task automatic rf_push(input logic [DW-1:0] d);
        rmem[wr_ptr] = d;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    // Scoreboard
    typedef struct { logic [DW-1:0] data; bit resp; } pop_t;
    logic [CW-1:0] q_cmd [$];
    logic [DW-1:0] q_wd  [$];
    pop_t          q_pop [$];
    bit            q_err [$];
    pop_t          mon_p;
    int n_cmp = 0;
    int n_bad = 0;
    int cmd_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h expected no event", name, act);
    endtask

    task automatic exp_pop(input logic [DW-1:0] d, input bit resp);
        pop_t p;
        p.data = d;
        p.resp = resp;
        q_pop.push_back(p);
    endtask

    // Monitor: compares every DUT-presented event against the queues
    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (CFIFO_WEN) begin
                cmd_count++;
                chk("cfifo_push_when_full", 64'(CFIFO_WFULL), 64'(0));
                if (q_cmd.size() == 0) unexpected("cmd_push", 64'(CFIFO_WDATA));
                else begin
                    chk("cmd_word", 64'(CFIFO_WDATA), 64'(q_cmd.pop_front()));
                    if (CFIFO_WDATA[CW-1]) chk("joint_push", 64'(WFIFO_WEN), 64'(1));
                end
            end
            if (WFIFO_WEN) begin
                chk("wfifo_push_when_full", 64'(WFIFO_WFULL), 64'(0));
                if (q_wd.size() == 0) unexpected("wdata_push", 64'(WFIFO_WDATA));
                else chk("wdata_word", 64'(WFIFO_WDATA), 64'(q_wd.pop_front()));
            end
            if (RFIFO_REN) begin
                if (q_pop.size() == 0) unexpected("rfifo_pop", 64'(RFIFO_RDATA));
                else begin
                    mon_p = q_pop.pop_front();
                    chk("rfifo_word", 64'(RFIFO_RDATA), 64'(mon_p.data));
                    if (mon_p.resp) begin
                        chk("rd_hreadyout", 64'(HREADYOUT), 64'(1));
                        chk("rd_hresp", 64'(HRESP), 64'(0));
                        chk("hrdata", 64'(HRDATA), 64'(mon_p.data));
                    end
                end
            end
            if (HRESP) begin
                if (q_err.size() == 0) unexpected("error_resp", 64'(HREADYOUT));
                else chk("err_hreadyout", 64'(HREADYOUT), 64'(q_err.pop_front()));
            end
        end
    end

    // Driver
    logic [DW-1:0] wbuf [4];
    int            rel_wfull_at = -1;
    int            rel_cfull_at = -1;
    int            fill_at      = -1;
    logic [DW-1:0] fill_data    = '0;

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic xfer(input bit wr, input logic [AW-1:0] base, input int n, output int waits);
        bit r;
        int guard;
        waits = 0;
        for (int b = 0; b <= n; b++) begin
            if (b < n) begin
                HSEL   = 1'b1;
                HTRANS = (b == 0) ? 2'b10 : 2'b11;
                HADDR  = base + AW'(4 * b);
                HWRITE = wr;
                HSIZE  = 3'b010;
                HBURST = (n > 1) ? 3'b011 : 3'b000;
                if (wr) begin
                    q_cmd.push_back({1'b1, 3'b010, base + AW'(4 * b)});
                    q_wd.push_back(wbuf[b]);
                end
            end else begin
                HSEL   = 1'b0;
                HTRANS = 2'b00;
            end
            if (b > 0 && wr) HWDATA = wbuf[b-1];
            guard = 0;
            r = 1'b0;
            while (!r && guard < 100) begin
                @(negedge HCLK);
                r = HREADYOUT;
                @(posedge HCLK);
                #1;
                guard++;
                if (!r) begin
                    waits++;
                    if (waits == rel_wfull_at) WFIFO_WFULL = 1'b0;
                    if (waits == rel_cfull_at) CFIFO_WFULL = 1'b0;
                    if (waits == fill_at) rf_push(fill_data);
                end
            end
            if (!r) unexpected("xfer_wait_budget", 64'(base));
        end
        rel_wfull_at = -1;
        rel_cfull_at = -1;
        fill_at      = -1;
    endtask

    int w;
    int c0;

    initial begin
        // Reset state
        #12;
        chk("rst_hreadyout", 64'(HREADYOUT), 64'(1));
        chk("rst_hresp", 64'(HRESP), 64'(0));
        chk("rst_strobes", 64'({CFIFO_WEN, WFIFO_WEN, RFIFO_REN}), 64'(0));
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        idle_cycles(2);

        // INCR4 write burst, zero wait
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA000_0000 + 32'(i);
        c0 = cmd_count;
        xfer(1'b1, 32'h100, 4, w);
        chk("burst_waits", 64'(w), 64'(0));
        chk("burst_cmd_count", 64'(cmd_count - c0), 64'(4));

        // Write stalled by a full write-data FIFO for 5 cycles
        wbuf[0] = 32'hCAFE_0001;
        WFIFO_WFULL  = 1'b1;
        rel_wfull_at = 5;
        c0 = cmd_count;
        xfer(1'b1, 32'h300, 1, w);
        chk("wfull_waits", 64'(w), 64'(5));
        chk("wfull_cmd_count", 64'(cmd_count - c0), 64'(1));

        // Read with data arriving 3 cycles after the command push
        q_cmd.push_back({1'b0, 3'b010, 32'h200});
        exp_pop(32'hDEAD_BEEF, 1'b1);
        fill_at = 3; fill_data = 32'hDEAD_BEEF;
        c0 = cmd_count;
        xfer(1'b0, 32'h200, 1, w);
        chk("read_waits", 64'(w), 64'(3));
        chk("read_cmd_count", 64'(cmd_count - c0), 64'(1));

        // Read timeout after command push, then late word discarded
        q_cmd.push_back({1'b0, 3'b010, 32'h400});
        q_err.push_back(1'b0);
        q_err.push_back(1'b1);
        xfer(1'b0, 32'h400, 1, w);
        chk("timeout_waits", 64'(w), 64'(9));
        exp_pop(32'h0000_1111, 1'b0);
        rf_push(32'h0000_1111);
        idle_cycles(3);
        chk("late_word_discarded", 64'(rd_ptr), 64'(wr_ptr));
        q_cmd.push_back({1'b0, 3'b010, 32'h500});
        exp_pop(32'h0000_2222, 1'b1);
        fill_at = 2; fill_data = 32'h0000_2222;
        xfer(1'b0, 32'h500, 1, w);
        chk("after_discard_waits", 64'(w), 64'(2));

        // Data arriving exactly at the timeout cycle wins
        q_cmd.push_back({1'b0, 3'b010, 32'h580});
        exp_pop(32'h5555_AAAA, 1'b1);
        fill_at = 8; fill_data = 32'h5555_AAAA;
        xfer(1'b0, 32'h580, 1, w);
        chk("data_wins_waits", 64'(w), 64'(8));

        // Timeout with the command FIFO full for 20 cycles: no command pushed
        CFIFO_WFULL = 1'b1;
        q_err.push_back(1'b0);
        q_err.push_back(1'b1);
        c0 = cmd_count;
        xfer(1'b0, 32'h600, 1, w);
        chk("cfull_timeout_waits", 64'(w), 64'(9));
        idle_cycles(11);
        CFIFO_WFULL = 1'b0;
        idle_cycles(2);
        chk("cfull_no_cmd", 64'(cmd_count - c0), 64'(0));
        q_cmd.push_back({1'b0, 3'b010, 32'h700});
        exp_pop(32'h0000_3333, 1'b1);
        fill_at = 1; fill_data = 32'h0000_3333;
        xfer(1'b0, 32'h700, 1, w);
        chk("no_drop_read_waits", 64'(w), 64'(1));

        // Asynchronous reset during a read wait
        q_cmd.push_back({1'b0, 3'b010, 32'h800});
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h800; HWRITE = 1'b0; HSIZE = 3'b010;
        @(posedge HCLK);
        #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        idle_cycles(3);
        #2;
        chk("pre_reset_hreadyout", 64'(HREADYOUT), 64'(0));
        HRESETn = 1'b0;
        #1;
        chk("async_rst_hreadyout", 64'(HREADYOUT), 64'(1));
        chk("async_rst_hresp", 64'(HRESP), 64'(0));
        chk("async_rst_strobes", 64'({CFIFO_WEN, WFIFO_WEN, RFIFO_REN}), 64'(0));
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        idle_cycles(1);
        wbuf[0] = 32'h9999_0000;
        xfer(1'b1, 32'h900, 1, w);
        chk("post_reset_write_waits", 64'(w), 64'(0));

        idle_cycles(2);
        chk("cmd_queue_drained", 64'(q_cmd.size()), 64'(0));
        chk("wdata_queue_drained", 64'(q_wd.size()), 64'(0));
        chk("pop_queue_drained", 64'(q_pop.size()), 64'(0));
        chk("err_queue_drained", 64'(q_err.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
